// File: rtl/ex_div.sv
// ex_div: iterative radix-2 restoring divider for the execute stage.
// One quotient bit per cycle; signed operands are divided as magnitudes
// and the signs are applied in a final correction cycle.
module ex_div #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o,
   output logic                 stallreq_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BYZERO = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t               state_q, state_nxt;
   logic [CNT_W-1:0]     cnt_q, cnt_nxt;
   logic [WIDTH-1:0]     rem_q, rem_nxt;
   logic [WIDTH-1:0]     quo_q, quo_nxt;
   logic [WIDTH-1:0]     dvs_q, dvs_nxt;
   logic                 sgn_q, sgn_nxt;
   logic                 neg1_q, neg1_nxt;
   logic                 neg2_q, neg2_nxt;
   logic [2*WIDTH-1:0]   result_q, result_nxt;
   logic                 ready_q, ready_nxt;

   logic [WIDTH:0]       shifted;
   logic [WIDTH:0]       diff;
   logic [WIDTH-1:0]     abs1, abs2;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   // Trial subtraction of the divisor from the shifted partial remainder
   assign shifted = {rem_q, quo_q[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvs_q};

   // Operand magnitudes for signed division (0x80000000 stays as its own magnitude)
   assign abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
   assign abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

   // Sign correction: quotient negative when signs differ, remainder follows dividend
   assign quo_fix = (sgn_q && (neg1_q ^ neg2_q)) ? (~quo_q + WIDTH'(1)) : quo_q;
   assign rem_fix = (sgn_q && neg1_q) ? (~rem_q + WIDTH'(1)) : rem_q;

   assign stallreq_o = start_i & ~ready_q;
   assign result_o   = result_q;
   assign ready_o    = ready_q;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         sgn_q    <= 1'b0;
         neg1_q   <= 1'b0;
         neg2_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         cnt_q    <= cnt_nxt;
         rem_q    <= rem_nxt;
         quo_q    <= quo_nxt;
         dvs_q    <= dvs_nxt;
         sgn_q    <= sgn_nxt;
         neg1_q   <= neg1_nxt;
         neg2_q   <= neg2_nxt;
         result_q <= result_nxt;
         ready_q  <= ready_nxt;
      end
   end

   // Next-state, datapath and registered-output logic
   always_comb begin
      state_nxt  = state_q;
      cnt_nxt    = cnt_q;
      rem_nxt    = rem_q;
      quo_nxt    = quo_q;
      dvs_nxt    = dvs_q;
      sgn_nxt    = sgn_q;
      neg1_nxt   = neg1_q;
      neg2_nxt   = neg2_q;
      result_nxt = result_q;
      ready_nxt  = ready_q;

      case (state_q)
         IDLE: begin
            ready_nxt  = 1'b0;
            result_nxt = '0;
            if (start_i && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_nxt = BYZERO;
               end else begin
                  state_nxt = RUN;
                  quo_nxt   = abs1;
                  dvs_nxt   = abs2;
                  sgn_nxt   = signed_div_i;
                  neg1_nxt  = opdata1_i[WIDTH-1];
                  neg2_nxt  = opdata2_i[WIDTH-1];
                  cnt_nxt   = '0;
                  rem_nxt   = '0;
               end
            end
         end

         BYZERO: begin
            if (annul_i) begin
               state_nxt  = IDLE;
               ready_nxt  = 1'b0;
               result_nxt = '0;
            end else begin
               state_nxt  = DONE;
               ready_nxt  = 1'b1;
               result_nxt = '0;
            end
         end

         RUN: begin
            if (annul_i) begin
               state_nxt  = IDLE;
               ready_nxt  = 1'b0;
               result_nxt = '0;
            end else if (cnt_q == CNT_W'(WIDTH)) begin
               state_nxt  = DONE;
               ready_nxt  = 1'b1;
               result_nxt = {rem_fix, quo_fix};
            end else begin
               if (!diff[WIDTH]) begin
                  rem_nxt = diff[WIDTH-1:0];
                  quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_nxt = shifted[WIDTH-1:0];
                  quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
               end
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end

         DONE: begin
            ready_nxt = 1'b1;
            if (!start_i) begin
               state_nxt  = IDLE;
               ready_nxt  = 1'b0;
               result_nxt = '0;
            end
         end

         default: begin
            state_nxt  = IDLE;
            ready_nxt  = 1'b0;
            result_nxt = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed vectors for ex_div with hand-computed results.
module tb_ex_div;

   logic        clk;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stallreq_o;

   int total;
   int bad;

   ex_div #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .stallreq_o   (stallreq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it if it mismatches
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
      end
   endtask

   // One full division handshake; samples 1 time unit after each rising edge
   task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp,
                          input int exp_lat, input bit scramble, input int hold);
      int  n;
      bit  stall_ok;
      @(negedge clk);
      signed_div_i = s;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      @(posedge clk); #1;
      n        = 1;
      stall_ok = (stallreq_o === 1'b1) || (ready_o === 1'b1);
      if (scramble) begin
         opdata1_i    = $urandom;
         opdata2_i    = $urandom;
         signed_div_i = ~s;
      end
      while (ready_o !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
         if (ready_o !== 1'b1 && stallreq_o !== 1'b1) stall_ok = 1'b0;
      end
      chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
      chk({tag, "_res"}, result_o, exp);
      chk({tag, "_stall_run"}, 64'(stall_ok), 64'd1);
      chk({tag, "_stall_done"}, 64'(stallreq_o), 64'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
         chk({tag, "_hold_res"}, result_o, exp);
      end
      start_i = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_idle_rdy"}, 64'(ready_o), 64'd0);
      chk({tag, "_idle_res"}, result_o, 64'd0);
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      rst          = 1'b0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdy", 64'(ready_o), 64'd0);
      chk("rst_res", result_o, 64'd0);
      chk("rst_stall", 64'(stallreq_o), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Unsigned and signed sign rules
      run_div("u100_7",   1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 34, 1'b0, 0);
      run_div("s_m7_2",   1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 34, 1'b0, 0);
      run_div("s_7_m2",   1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 34, 1'b0, 0);
      run_div("s_m7_m2",  1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003, 34, 1'b0, 0);
      run_div("u_m7_2",   1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 34, 1'b0, 0);

      // Edge operands
      run_div("s_min_m1", 1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 34, 1'b0, 0);
      run_div("u_min_m1", 1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 34, 1'b0, 0);
      run_div("u_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 34, 1'b0, 0);

      // Divide by zero
      run_div("div0",     1'b0, 32'd5,          32'd0,          64'h0, 2, 1'b0, 0);

      // Hold after ready and operand isolation during RUN
      run_div("hold",     1'b1, 32'hFFFFFF9C,   32'd7,          64'hFFFFFFFE_FFFFFFF2, 34, 1'b1, 5);

      // Annul at iteration 10
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      #1;
      annul_i = 1'b1;
      start_i = 1'b0;
      @(posedge clk); #1;
      annul_i = 1'b0;
      chk("annul_rdy", 64'(ready_o), 64'd0);
      chk("annul_res", result_o, 64'd0);
      begin
         bit rose;
         rose = 1'b0;
         repeat (30) begin
            @(posedge clk); #1;
            if (ready_o === 1'b1) rose = 1'b1;
         end
         chk("annul_no_rdy", 64'(rose), 64'd0);
      end
      run_div("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, 1'b0, 0);

      // Asynchronous reset at iteration 20
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd1000;
      opdata2_i    = 32'd3;
      start_i      = 1'b1;
      @(posedge clk);
      repeat (20) @(posedge clk);
      #2;
      rst     = 1'b0;
      start_i = 1'b0;
      #1;
      chk("arst_rdy", 64'(ready_o), 64'd0);
      chk("arst_res", result_o, 64'd0);
      chk("arst_stall", 64'(stallreq_o), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("arst_no_rdy", 64'(ready_o), 64'd0);

      run_div("after_rst", 1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 34, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Iterative 32-bit radix-2 divider for the execute stage.
- Sits beside the ex stage and consumes the operands that id_ex registers (ex_reg1 = dividend, ex_reg2 = divisor).
- ex asserts start for DIV/DIVU, holds the pipeline stalled via stallreq_o, and writes HI/LO from result_o once ready_o is high.
- Handles signed and unsigned division, divide-by-zero, and cancellation from exceptions/flush.

Parameters:
- WIDTH, 32, operand width; result_o is 2*WIDTH. Only 32 is verified.

Ports:
- clk  input  1  Rising-edge clock.
- rst  input  1  Reset, asynchronous, active-low (0 = reset).
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- opdata1_i  input  WIDTH  Dividend; sampled with start.
- opdata2_i  input  WIDTH  Divisor; sampled with start.
- start_i  input  1  Request; held high by ex until it has consumed ready_o.
- annul_i  input  1  Cancel in-flight operation (flush/exception).
- result_o  output  2*WIDTH  [63:32] = remainder (HI), [31:0] = quotient (LO).
- ready_o  output  1  Result valid.
- stallreq_o  output  1  Combinational: start_i & ~ready_o.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, result_o=0, ready_o=0, internal registers cleared. Reset mid-operation aborts immediately; no result is produced.
- States: IDLE, BYZERO, RUN, DONE.
- IDLE:
  - start_i=1 and annul_i=0 and opdata2_i==0 -> BYZERO.
  - start_i=1 and annul_i=0 and divisor nonzero -> RUN. Latch the absolute values of the operands when signed_div_i=1 (raw values otherwise), latch both sign bits and signed_div_i, set cnt=0, clear the partial remainder.
  - Otherwise stay in IDLE with ready_o=0 and result_o=0.
- BYZERO: next edge -> DONE with result_o=0.
- RUN, when cnt<32:
  - Shift {rem, quo} left by one bit, bringing in the next dividend bit MSB-first.
  - Trial-subtract the divisor from the remainder. If non-negative, keep the difference and set quotient bit=1; else quotient bit=0.
  - cnt++.
- RUN, when cnt==32: apply sign correction and go to DONE.
  - Quotient is negated if signed and the operand signs differ.
  - Remainder is negated if signed and the dividend is negative; the remainder takes the dividend's sign.
- Modular wrap: 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0. No trap.
- annul_i=1 in BYZERO or RUN: next edge -> IDLE with ready_o=0 and result_o=0. No result is produced. annul_i has priority over every other transition.
- DONE:
  - ready_o=1 and result_o holds the result.
  - Stays in DONE while start_i=1.
  - start_i=0 -> IDLE next edge, with ready_o=0 and result_o=0.
  - Result is not recomputed while start_i stays high.
- Latency, with E0 = the edge that samples start_i in IDLE:
  - Normal operation: iterations occur on E1..E32, finalize on E33, ready_o=1 after E33 (34 edges total).
  - Divide-by-zero: ready_o=1 after E1.
- Inputs opdata1_i, opdata2_i and signed_div_i are ignored outside IDLE. Changing them mid-run has no effect.
- stallreq_o is high from the cycle start_i rises until ready_o=1, and is never high while start_i=0.

Test Plan:
- Unsigned 100 / 7: start held -> ready_o rises exactly 34 edges after the sampling edge; result_o = 0x00000002_0000000E; stallreq_o high for 34 cycles, then low.
- Signed sign rules:
  - -7 / 2 -> 0xFFFFFFFF_FFFFFFFD.
  - 7 / -2 -> 0x00000001_FFFFFFFD.
  - -7 / -2 -> 0xFFFFFFFF_00000003.
  - Same -7 / 2 operand bits with signed_div_i=0 -> 0x00000001_7FFFFFFC.
- Edge operands:
  - 0x80000000 / 0xFFFFFFFF signed -> 0x00000000_80000000.
  - 0x80000000 / 0xFFFFFFFF unsigned -> 0x80000000_00000000.
  - 0xFFFFFFFF / 1 unsigned -> 0x00000000_FFFFFFFF.
- Divide-by-zero, 5 / 0 -> ready_o=1 after 2 edges with result_o=0; after start_i drops, the next edge returns to IDLE with ready_o=0.
- Annul and reset mid-operation:
  - annul_i pulsed at iteration 10 -> IDLE, ready_o never rises; an immediately following 9/3 returns 0x00000000_00000003 after 34 edges.
  - rst=0 asynchronously at iteration 20 -> all outputs 0 with no clock edge needed.
- Hold and input isolation: start_i kept high 5 cycles after ready -> ready_o and result_o stable; operand inputs toggled during RUN do not change the result.
